// File: rtl/mem_access_pkg.sv
// Shared StoreLoad defines for the multicycle memory access sequencer: access-size codes,
// sequencer state encodings, the latched request context and size/alignment helpers.
package mem_access_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned SIZE_W = 3;

  // StoreLoad access-size codes; the U variants move the same number of bytes as the signed ones
  localparam logic [SIZE_W-1:0] SL_BYTE  = 3'b000;
  localparam logic [SIZE_W-1:0] SL_HALF  = 3'b001;
  localparam logic [SIZE_W-1:0] SL_WORD  = 3'b010;
  localparam logic [SIZE_W-1:0] SL_BYTEU = 3'b100;
  localparam logic [SIZE_W-1:0] SL_HALFU = 3'b101;

  localparam logic [1:0] SL_ST_IDLE = 2'd0;
  localparam logic [1:0] SL_ST_REQ  = 2'd1;
  localparam logic [1:0] SL_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = SL_ST_IDLE,
    ST_REQ  = SL_ST_REQ,
    ST_DONE = SL_ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_cls_e;

  // Request fields the lane steering still needs after the request has been accepted
  typedef struct packed {
    logic              we;
    logic [SIZE_W-1:0] size;
    logic [1:0]        lo;
  } req_ctx_t;

  // Unrecognised codes fall through to a full word access
  function automatic size_cls_e size_class(input logic [SIZE_W-1:0] code);
    size_cls_e cls;
    case (code)
      SL_BYTE, SL_BYTEU: cls = SZ_BYTE;
      SL_HALF, SL_HALFU: cls = SZ_HALF;
      default:           cls = SZ_WORD;
    endcase
    return cls;
  endfunction

  function automatic logic misaligned(input logic [SIZE_W-1:0] code, input logic [1:0] lo);
    logic bad;
    case (size_class(code))
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering between a right-justified CPU view and the word-wide memory bus:
// store byte enables and replicated store data, and right-justified, zero-filled load data.
module mem_lane_steer
  import mem_access_pkg::*;
(
  input  logic              we,
  input  logic [SIZE_W-1:0] size,
  input  logic [1:0]        lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [BE_W-1:0]   be_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic [XLEN-1:0]   rdata_c
);

  // Loads always fetch the whole word; only stores narrow the enables
  always_comb begin
    be_c    = '1;
    wdata_c = wdata;
    rdata_c = rdata;
    case (size_class(size))
      SZ_BYTE: begin
        if (we) be_c = BE_W'(4'b0001 << lo);
        wdata_c = {4{wdata[7:0]}};
        rdata_c = (rdata >> {lo, 3'b000}) & 32'h0000_00ff;
      end
      SZ_HALF: begin
        if (we) be_c = BE_W'(4'b0011 << lo);
        wdata_c = {2{wdata[15:0]}};
        rdata_c = (rdata >> {lo[1], 4'b0000}) & 32'h0000_ffff;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Multicycle load/store sequencer: one request at a time onto a req/ack word bus, loads steered into the MDR.
// Optional bus timeout is built in when MEM_TIMEOUT_EN is defined (TIMEOUT_CYCLES wait cycles before abort).
module mem_access
  import mem_access_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [SIZE_W-1:0] size,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic [XLEN-1:0]   mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e          state, state_nx;
  req_ctx_t        ctx, steer_ctx_c;
  logic            accept_c, misalign_c, tmo_hit_c;
  logic            err_nx;
  logic [XLEN-1:0] mdr_nx;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c, rdata_c;

  // In IDLE the steering sees the incoming request; afterwards the latched one
  always_comb begin
    steer_ctx_c = ctx;
    if (state == ST_IDLE) steer_ctx_c = '{we: we, size: size, lo: addr[1:0]};
  end

  mem_lane_steer u_steer (
    .we      (steer_ctx_c.we),
    .size    (steer_ctx_c.size),
    .lo      (steer_ctx_c.lo),
    .wdata   (wdata),
    .rdata   (mem_rdata),
    .be_c    (be_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Held at zero outside REQ, so every bus cycle starts counting afresh
  always_ff @(posedge clk) begin
    if (!rst_n || state != ST_REQ) tmo_cnt <= '0;
    else if (!mem_ack)             tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
  end

  assign tmo_hit_c = (TMO_W'(tmo_cnt + 1'b1) == TMO_W'(TIMEOUT_CYCLES));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Next state plus next err/mdr; ack is tested before expiry so a late ack still completes
  always_comb begin
    state_nx   = state;
    accept_c   = 1'b0;
    err_nx     = err;
    mdr_nx     = mdr;
    misalign_c = misaligned(size, addr[1:0]);
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          err_nx   = misalign_c;
          state_nx = misalign_c ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_nx = ST_DONE;
          if (!ctx.we) mdr_nx = rdata_c;
        end else if (tmo_hit_c) begin
          err_nx   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Status outputs are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctx       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      mdr       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_req <= (state_nx == ST_REQ);
      busy    <= (state_nx != ST_IDLE);
      done    <= (state_nx == ST_DONE);
      err     <= err_nx;
      mdr     <= mdr_nx;
      if (accept_c) begin
        ctx       <= steer_ctx_c;
        mem_we    <= we;
        mem_addr  <= {addr[XLEN-1:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wdata_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written corner sequences and
// randomized transactions checked against a byte-arithmetic reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] mdr;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .we        (we),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mdr       (mdr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );
`else
  mem_access dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .we        (we),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mdr       (mdr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access width in bytes and byte-lane arithmetic
  function automatic int nbytes_of(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic w, input int nb, input int off);
    if (!w) return 4'hF;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] d, input int nb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] d, input int nb, input int off);
    logic [63:0] v;
    v = {32'd0, d} >> (8 * off);
    if (nb < 4) v = v & ((64'd1 << (8 * nb)) - 64'd1);
    return v[31:0];
  endfunction

  typedef struct {
    int          done_cyc;
    int          nreq;
    logic        err;
    logic [31:0] mdr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] addr;
    logic        we;
    logic        stable;
    logic        busy_ok;
    logic        idle_ok;
  } obs_t;

  // Drives one request from an IDLE cycle, plays the memory (ack after 'waits' req cycles),
  // and ends one cycle after done, back in IDLE.
  task automatic do_txn(input logic t_we, input logic [2:0] t_size, input logic [31:0] t_addr,
                        input logic [31:0] t_wdata, input logic [31:0] t_rdata, input int waits,
                        output obs_t o);
    o = '{done_cyc: -1, nreq: 0, err: 1'b0, mdr: 32'd0, be: 4'd0, wd: 32'd0, addr: 32'd0,
          we: 1'b0, stable: 1'b1, busy_ok: 1'b1, idle_ok: 1'b0};
    start = 1'b1; we = t_we; size = t_size; addr = t_addr; wdata = t_wdata; mem_ack = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
      if (!busy) o.busy_ok = 1'b0;
      if (mem_req) begin
        if (o.nreq == 0) begin
          o.be = mem_be; o.wd = mem_wdata; o.addr = mem_addr; o.we = mem_we;
        end else if ({mem_be, mem_wdata, mem_addr, mem_we} != {o.be, o.wd, o.addr, o.we}) begin
          o.stable = 1'b0;
        end
        o.nreq++;
        if (o.nreq == waits + 1) begin
          mem_ack = 1'b1; mem_rdata = t_rdata;
        end
      end
      if (done) begin
        o.done_cyc = cyc; o.err = err; o.mdr = mdr;
        break;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    o.idle_ok = !busy && !done && !mem_req;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] mdr;
    logic        err;
    int          done_cyc;
  } vec_t;

  vec_t vecs[12];
  obs_t o;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] model_mdr;
    int          nreq_acc;

    vecs[0]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    vecs[1]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 0, 4'hF, 32'h0,         32'h0000_0080, 1'b0, 2};
    vecs[2]  = '{1'b1, 3'd1, 32'h0000_0002, 32'h1234_ABCD, 32'h0,         3, 4'hC, 32'hABCD_ABCD, 32'h0000_0080, 1'b0, 5};
    vecs[3]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,         32'h1111_1111, 0, 4'h0, 32'h0,         32'h0000_0080, 1'b1, 1};
    vecs[4]  = '{1'b0, 3'd5, 32'h0000_0006, 32'h0,         32'h1122_3344, 1, 4'hF, 32'h0,         32'h0000_1122, 1'b0, 3};
    vecs[5]  = '{1'b1, 3'd0, 32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 4'h2, 32'hA5A5_A5A5, 32'h0000_1122, 1'b0, 2};
    vecs[6]  = '{1'b0, 3'd7, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 0, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0, 2};
    vecs[7]  = '{1'b1, 3'd1, 32'h0000_0001, 32'h5555_5555, 32'h0,         0, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b1, 1};
    vecs[8]  = '{1'b0, 3'd4, 32'h0000_0012, 32'h0,         32'h00CD_0000, 2, 4'hF, 32'h0,         32'h0000_00CD, 1'b0, 4};
    vecs[9]  = '{1'b1, 3'd2, 32'h0000_0003, 32'h9999_9999, 32'h0,         0, 4'h0, 32'h0,         32'h0000_00CD, 1'b1, 1};
    vecs[10] = '{1'b1, 3'd2, 32'h0000_0004, 32'h89AB_CDEF, 32'h0,         0, 4'hF, 32'h89AB_CDEF, 32'h0000_00CD, 1'b0, 2};
    vecs[11] = '{1'b0, 3'd1, 32'h0000_0000, 32'h0,         32'hFFFF_8001, 0, 4'hF, 32'h0,         32'h0000_8001, 1'b0, 2};

    rst_n = 1'b0; start = 1'b0; we = 1'b0; size = 3'd0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ctrl", {27'd0, mem_req, mem_we, busy, done, err}, 32'd0);
    check("reset be", {28'd0, mem_be}, 32'd0);
    check("reset addr", mem_addr, 32'd0);
    check("reset wdata", mem_wdata, 32'd0);
    check("reset mdr", mdr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].waits, o);
      check($sformatf("vec%0d done_cycle", i), o.done_cyc, vecs[i].done_cyc);
      check($sformatf("vec%0d err", i), {31'd0, o.err}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d mdr", i), o.mdr, vecs[i].mdr);
      check($sformatf("vec%0d req_cycles", i), o.nreq, vecs[i].err ? 0 : vecs[i].done_cyc - 1);
      check($sformatf("vec%0d busy/idle", i), {30'd0, o.busy_ok, o.idle_ok}, 32'd3);
      if (!vecs[i].err) begin
        check($sformatf("vec%0d be", i), {28'd0, o.be}, {28'd0, vecs[i].be});
        check($sformatf("vec%0d mem_addr", i), o.addr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("vec%0d we/stable", i), {30'd0, o.we, o.stable}, {30'd0, vecs[i].we, 1'b1});
        if (vecs[i].we) check($sformatf("vec%0d mem_wdata", i), o.wd, vecs[i].wd);
      end
      if (i == 1) check("vec1 sign-extended", {{24{o.mdr[7]}}, o.mdr[7:0]}, 32'hFFFF_FF80);
    end

    // Randomized transactions against the reference model
    model_mdr = 32'h0000_8001;
    for (int k = 0; k < 60; k++) begin
      logic        r_we, mis;
      logic [2:0]  r_sz;
      logic [31:0] r_a, r_wd, r_rd;
      int          r_w, nb, off;
      r_we = 1'($urandom_range(0, 1));
      r_sz = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_wd = $urandom;
      r_rd = $urandom;
      r_w  = $urandom_range(0, 3);
      nb   = nbytes_of(r_sz);
      off  = int'(r_a[1:0]);
      mis  = (off % nb) != 0;
      if (!mis && !r_we) model_mdr = model_load(r_rd, nb, off);
      do_txn(r_we, r_sz, r_a, r_wd, r_rd, r_w, o);
      check($sformatf("rnd%0d done_cycle", k), o.done_cyc, mis ? 1 : r_w + 2);
      check($sformatf("rnd%0d err", k), {31'd0, o.err}, {31'd0, mis});
      check($sformatf("rnd%0d mdr", k), o.mdr, model_mdr);
      check($sformatf("rnd%0d req_cycles", k), o.nreq, mis ? 0 : r_w + 1);
      if (!mis) begin
        check($sformatf("rnd%0d be", k), {28'd0, o.be}, {28'd0, model_be(r_we, nb, off)});
        check($sformatf("rnd%0d mem_addr", k), o.addr, r_a & 32'hFFFF_FFFC);
        check($sformatf("rnd%0d stable", k), {31'd0, o.stable}, 32'd1);
        if (r_we) check($sformatf("rnd%0d mem_wdata", k), o.wd, model_wd(r_wd, nb));
      end
    end

    // Ack while idle must not disturb mdr or start anything
    mem_ack = 1'b1;
    repeat (3) begin
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    check("idle ack mdr", mdr, model_mdr);
    check("idle ack status", {29'd0, busy, done, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // Start while busy is ignored; reset in the second REQ cycle aborts the access
    start = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h0000_0040;
    @(posedge clk); #1;
    check("rst seq req1", {31'd0, mem_req}, 32'd1);
    addr = 32'h0000_0080;
    @(posedge clk); #1;
    check("busy start addr", mem_addr, 32'h0000_0040);
    check("rst seq req2", {31'd0, mem_req}, 32'd1);
    start = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst in req status", {30'd0, mem_req, busy}, 32'd0);
    check("rst in req mdr", mdr, 32'd0);
    rst_n = 1'b1;
    nreq_acc = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_req || busy) nreq_acc++;
    end
    check("no txn after ignored start", nreq_acc, 0);

`ifdef MEM_TIMEOUT_EN
    do_txn(1'b0, 3'd2, 32'h20, 32'd0, 32'h5A5A_1234, 0, o);
    check("tmo preload mdr", o.mdr, 32'h5A5A_1234);
    do_txn(1'b0, 3'd2, 32'h24, 32'd0, 32'h1111_1111, 1000, o);
    check("tmo req_cycles", o.nreq, 4);
    check("tmo done_cycle", o.done_cyc, 5);
    check("tmo err", {31'd0, o.err}, 32'd1);
    check("tmo mdr held", o.mdr, 32'h5A5A_1234);
    do_txn(1'b0, 3'd2, 32'h28, 32'd0, 32'h0000_0077, 3, o);
    check("ack at expiry err", {31'd0, o.err}, 32'd0);
    check("ack at expiry mdr", o.mdr, 32'h0000_0077);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Multicycle memory access sequencer for the MIPS datapath: accepts one load/store request from the control unit, drives a word-addressed memory bus with byte enables and a req/ack handshake, and registers the returned load data into the MDR. Load data is lane-steered so the addressed byte or halfword lands in the MDR's low bits, ready for the downstream sign/zero-extension stage. It also flags misaligned accesses and, optionally, bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255: WAIT-state cycles before abort (used only with timeout feature)
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  3  access-size code from the shared StoreLoad defines (Byte/Half/Word, U variants = same size as signed)
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  bus read data, valid with mem_ack
- mem_ack  in  1  bus acknowledge
- mdr  out  32  registered, lane-steered load data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  registered; set with done on misalign/timeout, cleared at next accepted start

## Operation
- States: IDLE, REQ, DONE. Reset → IDLE; all outputs 0.
- IDLE + start: latch we/size/addr/wdata. If misaligned (Half with addr[0]=1; Word with addr[1:0]≠0) → DONE with err=1, no bus cycle. Else → REQ.
- REQ: mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata. On mem_ack: load → mdr captures steered data; store → mdr unchanged; → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Byte enables: load 4'b1111; store Byte 4'b0001<<addr[1:0], Half 4'b0011<<addr[1:0], Word 4'b1111.
- Store data: Byte {4{wdata[7:0]}}, Half {2{wdata[15:0]}}, Word wdata.
- Load steering: Byte mem_rdata>>(8·addr[1:0]), Half mem_rdata>>(16·addr[1]), Word mem_rdata; vacated high bits zero (extension is downstream).
- Unrecognised size code treated as Word.
- start while busy=1: ignored, no queuing.
- mem_ack outside REQ: ignored.

## Timing
- start at edge 0 → mem_req high from edge 1. Ack sampled same cycle as req allowed: ack at cycle 1 → mdr valid and done=1 in cycle 2 → IDLE, new start accepted in cycle 2's following edge (start sampled in cycle 3).
- Zero-wait load latency: 2 cycles start→done; each ack wait state adds 1.
- Misaligned: done=err=1 in cycle 1, mem_req never asserted.
- rst_n low during REQ: next edge mem_req=0, state IDLE, mdr=0.
- mdr holds value until next successful load.

## Configuration
- MEM_TIMEOUT_EN defined: counter clears on entry to REQ, increments each REQ cycle without ack; when it reaches TIMEOUT_CYCLES, mem_req drops, → DONE with err=1, mdr unchanged. Ack on the same cycle as expiry wins (normal completion).
- Undefined: no counter; REQ waits indefinitely for ack.

## Structure
- Size codes (Byte/Half/Word/ByteU/HalfU) stay in the shared StoreLoad defines; state encodings (IDLE/REQ/DONE) added there as constants.
- One combinational sub-module, mem_lane_steer: computes mem_be, mem_wdata and steered load data from size, addr[1:0], wdata, mem_rdata. FSM, counter and registers stay in mem_access.

## Test plan
- Load Word addr 0x100, ack after 0 waits, rdata 0xDEADBEEF → mem_be=4'hF, mdr=0xDEADBEEF, done at cycle 2, err=0.
- Load Byte addr 0x103, rdata 0x80AABBCC → mem_addr=0x100, mdr=0x00000080; downstream extension yields 0xFFFFFF80.
- Store Half addr 0x2, wdata 0x1234ABCD, ack after 3 waits → mem_be=4'b1100, mem_wdata=0xABCDABCD held 4 cycles, done at cycle 5.
- Load Word addr 0x102 → no mem_req, done=err=1 at cycle 1; next aligned start clears err.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → mem_req drops after 4 REQ cycles, done=err=1, mdr unchanged.
- rst_n low in REQ cycle 2, start pulsed while busy → mem_req=0 next edge, busy=0, ignored start produces no transaction.
